dmem_arbiter: RTL

Two-port arbiter that shares the single-port data memory between the pipeline MEM stage (port A) and a debug/DMA loader (port B). It grants one requester per cycle, muxes address, write data and write enable onto the memory, and routes the one-cycle-latency read data back to the requester that issued the read. Port A has priority. A starvation counter forces a port-B grant after a bounded number of consecutive denials. The block sits between the pipeline/debug masters and the data memory instance.

---
 rtl/dmem_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the pipeline MEM stage (A, priority)
// and a debug/DMA loader (B), with a starvation guard that forces a B grant.
`default_nettype none

module dmem_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_a_req,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_wdata,
  output logic          o_a_gnt,
  output logic          o_a_rvalid,
  output logic [DW-1:0] o_a_rdata,
  input  logic          i_b_req,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_wdata,
  output logic          o_b_gnt,
  output logic          o_b_rvalid,
  output logic [DW-1:0] o_b_rdata,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_we,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam logic [0:0] S_A_PRI   = 1'b0;
  localparam logic [0:0] S_B_FORCE = 1'b1;
  localparam logic [3:0] C_STARVE_LAST = 4'(STARVE_LIMIT - 1);

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_nxt;
  logic [1:0] r_rd_owner;   // [1] = A, [0] = B
  logic       w_b_denied;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_A_PRI;
      r_starve_cnt <= 4'd0;
      r_rd_owner   <= 2'b00;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_rd_owner   <= {o_a_gnt & ~i_a_we, o_b_gnt & ~i_b_we};
    end
  end

  assign w_b_denied = i_b_req & ~o_b_gnt;

  always_comb begin
    w_state_nxt  = S_A_PRI;
    w_starve_nxt = w_b_denied ? r_starve_cnt + 4'd1 : 4'd0;
    if (r_state == S_A_PRI && w_b_denied && r_starve_cnt == C_STARVE_LAST)
      w_state_nxt = S_B_FORCE;
  end

  // Grants are gated by reset so nothing reaches the memory while rst_n is low.
  always_comb begin
    o_a_gnt = 1'b0;
    o_b_gnt = 1'b0;
    if (rst_n) begin
      if (r_state == S_B_FORCE) begin
        o_b_gnt = i_b_req;
        o_a_gnt = i_a_req & ~i_b_req;
      end else begin
        o_a_gnt = i_a_req;
        o_b_gnt = i_b_req & ~i_a_req;
      end
    end
  end

  assign o_mem_addr  = o_b_gnt ? i_b_addr  : i_a_addr;
  assign o_mem_wdata = o_b_gnt ? i_b_wdata : i_a_wdata;
  assign o_mem_we    = (o_a_gnt & i_a_we) | (o_b_gnt & i_b_we);

  assign o_a_rvalid = r_rd_owner[1];
  assign o_b_rvalid = r_rd_owner[0];
  assign o_a_rdata  = i_mem_rdata;
  assign o_b_rdata  = i_mem_rdata;

endmodule

`default_nettype wire
